mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs and performs loads and stores over a variable-latency req/ack data-memory port.
- Selects the writeback value and registers the MEM/WB outputs internally.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles before abandoning a request (1..65535).
- ADDR_W, 32: byte-address width on the memory port.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  EX/MEM holds a real instruction
- ALUout_i  in  32  effective address / ALU result
- regOp2_i  in  32  store data
- RegWrite_i  in  1  instruction writes rd
- WriteSrc_i  in  2  00 ALU, 01 load data, 10 pcPlus4, 11 ImmOp
- MemWrite_i  in  1  store
- memSize_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ImmOp_i  in  32  immediate (LUI path)
- pcPlus4_i  in  32  link value
- rd_i  in  5  destination register
- stall_o  out  1  upstream must hold EX/MEM contents
- mem_req_o  out  1  request valid
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata_o  out  32  lane-replicated store data
- mem_be_o  out  4  byte enables
- mem_ack_i  in  1  request completed; rdata valid this cycle for reads
- mem_rdata_i  in  32  read word
- valid_o  out  1  MEM/WB holds a real instruction
- RegWrite_o  out  1  gated writeback enable
- rd_o  out  5  destination
- result_o  out  32  writeback value
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous active-low.
- Reset state: IDLE. All outputs and internal registers are 0, including mem_req_o, valid_o, RegWrite_o and bus_err_o.
- A memory op is valid_i & (MemWrite_i | WriteSrc_i==01).
- States:
  - IDLE:
    - Non-memory op: MEM/WB registers load next edge (1-cycle latency). stall_o=0.
    - Memory op: stall_o=1 combinationally. At the edge, latch addr/be/wdata/we/rd/size/RegWrite, set mem_req_o=1, clear the timeout counter, go to WAIT. MEM/WB loads a bubble (valid_o=0, RegWrite_o=0).
  - WAIT:
    - mem_req_o and all request fields are held stable. Counter increments each cycle. stall_o = ~mem_ack_i.
    - On mem_ack_i: MEM/WB loads from the latched fields. Load data is taken from mem_rdata_i. mem_req_o drops next edge. Go to IDLE. stall_o=0 that cycle so upstream advances.
    - Counter reaching TIMEOUT_CYCLES with no ack: drop req, pulse bus_err_o. MEM/WB loads with valid_o=1, RegWrite_o=0. Go to IDLE.
- Minimum load/store latency: 2 cycles (ack in the first WAIT cycle).
- An ack in IDLE is ignored.
- Store lanes:
  - B: be = 1<<addr[1:0], wdata = {4{op2[7:0]}}.
  - H: be = 0011 or 1100 by addr[1], wdata = {2{op2[15:0]}}.
  - W: be = 1111.
- Load extract: select byte/half by the latched addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU.
- Misaligned addresses (H with addr[0]=1, W with addr[1:0]!=0) use the truncated lane; no fault without the optional feature.
- RegWrite_o = valid & RegWrite; forced 0 for bubbles and timeouts.
- Reset mid-WAIT: mem_req_o deasserts immediately (async) and the transaction is abandoned. The memory side tolerates this.
- Undefined memSize_i encodings are treated as W.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - A misaligned memory op in IDLE issues no request and does not enter WAIT.
  - MEM/WB loads valid_o=1, RegWrite_o=0, misalign_o=1 for one cycle. stall_o=0.
- Undefined: port absent; misaligned accesses behave as in Behaviour.

Decomposition:
- Shared package riscv_pkg:
  - WriteSrc encoding enum (WS_ALU, WS_MEM, WS_PC4, WS_IMM).
  - memSize funct3 constants.
  - State enum {S_IDLE, S_WAIT}.
- Sub-module load_extend: combinational. Inputs rdata, addr[1:0], size; output extended 32-bit value.

Test Plan:
- ALU op, WriteSrc=00, ALUout=0x1234, rd=5 -> next cycle valid_o=1, result_o=0x1234, rd_o=5, stall_o never high, mem_req_o never high.
- LB addr 0x103, ack one cycle after req with rdata=0x80FFFFFF -> stall_o high 2 cycles, result_o=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr 0x102, op2=0xABCD1234, ack after 3 WAIT cycles -> mem_we_o=1, mem_addr_o=0x100, mem_be_o=1100, mem_wdata_o=0x12341234 stable throughout. RegWrite_o=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> req dropped after 4 WAIT cycles, bus_err_o pulses once, RegWrite_o=0, next instruction accepted.
- rst_ni asserted mid-WAIT -> mem_req_o, valid_o and stall_o are 0 immediately; after release, an LW completes normally.
- MISALIGN_TRAP_EN: LW addr 0x101 -> no mem_req_o, misalign_o=1 one cycle, RegWrite_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: writeback source, load/store size codes, MEM-stage state
// and the per-request context latched while a memory access is outstanding.
package riscv_pkg;

    typedef enum logic [1:0] {
        WS_ALU = 2'b00,
        WS_MEM = 2'b01,
        WS_PC4 = 2'b10,
        WS_IMM = 2'b11
    } write_src_e;

    localparam logic [2:0] MS_B  = 3'b000;
    localparam logic [2:0] MS_H  = 3'b001;
    localparam logic [2:0] MS_W  = 3'b010;
    localparam logic [2:0] MS_BU = 3'b100;
    localparam logic [2:0] MS_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic        is_load;
        logic        reg_write;
        logic [4:0]  rd;
        logic [2:0]  size;
        logic [1:0]  lane;
        logic [31:0] alt;
    } mem_ctx_t;

    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            MS_B, MS_BU: store_be = 4'(4'b0001 << lane);
            MS_H, MS_HU: store_be = lane[1] ? 4'b1100 : 4'b0011;
            default:     store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] data);
        case (size)
            MS_B, MS_BU: store_wdata = {4{data[7:0]}};
            MS_H, MS_HU: store_wdata = {2{data[15:0]}};
            default:     store_wdata = data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            MS_B, MS_BU: is_misaligned = 1'b0;
            MS_H, MS_HU: is_misaligned = lane[0];
            default:     is_misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port of the MEM stage; the stage is the master.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load lane select and sign/zero extension of a read word.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[7:0];
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_i)
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            2'd3:    byte_v = rdata_i[31:24];
            default: byte_v = rdata_i[7:0];
        endcase
    end

    always_comb begin
        case (size_i)
            MS_B:    data_o = {{24{byte_v[7]}}, byte_v};
            MS_BU:   data_o = {24'd0, byte_v};
            MS_H:    data_o = {{16{half_v[15]}}, half_v};
            MS_HU:   data_o = {16'd0, half_v};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores on a variable-latency req/ack port, stalls upstream
// while outstanding, and registers MEM/WB. Optional MISALIGN_TRAP_EN adds misalign_o.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] regOp2_i,
    input  logic        RegWrite_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  memSize_i,
    input  logic [31:0] ImmOp_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    mem_access_stage_if.master mem,
    output logic        valid_o,
    output logic        RegWrite_o,
    output logic [4:0]  rd_o,
    output logic [31:0] result_o,
    output logic        bus_err_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_ctx_t          ctx_q, ctx_d;
    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       result_q, result_d;
    logic              bus_err_q, bus_err_d;

    logic              mem_op_c;
    logic              trap_c;
    logic              stall_c;
    logic [31:0]       wb_sel_c;
    logic [31:0]       load_data_c;

    assign mem_op_c = valid_i & (MemWrite_i | (WriteSrc_i == WS_MEM));

`ifdef MISALIGN_TRAP_EN
    assign trap_c = mem_op_c & is_misaligned(memSize_i, ALUout_i[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    always_comb begin
        case (write_src_e'(WriteSrc_i))
            WS_PC4:  wb_sel_c = pcPlus4_i;
            WS_IMM:  wb_sel_c = ImmOp_i;
            default: wb_sel_c = ALUout_i;
        endcase
    end

    load_extend u_load_extend (
        .rdata_i (mem.mem_rdata_i),
        .addr_i  (ctx_q.lane),
        .size_i  (ctx_q.size),
        .data_o  (load_data_c)
    );

    // Next state; MEM/WB defaults to a bubble every cycle unless something retires.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        ctx_d      = ctx_q;
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        result_d   = result_q;
        bus_err_d  = 1'b0;
        stall_c    = 1'b0;

        if (state_q == S_IDLE) begin
            if (trap_c) begin
                valid_d  = 1'b1;
                rd_d     = rd_i;
                result_d = ALUout_i;
            end else if (mem_op_c) begin
                stall_c         = 1'b1;
                state_d         = S_WAIT;
                req_d           = 1'b1;
                we_d            = MemWrite_i;
                addr_d          = {ALUout_i[ADDR_W-1:2], 2'b00};
                wdata_d         = store_wdata(memSize_i, regOp2_i);
                be_d            = store_be(memSize_i, ALUout_i[1:0]);
                cnt_d           = '0;
                ctx_d.is_load   = (WriteSrc_i == WS_MEM);
                ctx_d.reg_write = RegWrite_i;
                ctx_d.rd        = rd_i;
                ctx_d.size      = memSize_i;
                ctx_d.lane      = ALUout_i[1:0];
                ctx_d.alt       = wb_sel_c;
            end else begin
                valid_d    = valid_i;
                regwrite_d = valid_i & RegWrite_i;
                rd_d       = rd_i;
                result_d   = wb_sel_c;
            end
        end else begin
            if (mem.mem_ack_i) begin
                state_d    = S_IDLE;
                req_d      = 1'b0;
                valid_d    = 1'b1;
                regwrite_d = ctx_q.reg_write;
                rd_d       = ctx_q.rd;
                result_d   = ctx_q.is_load ? load_data_c : ctx_q.alt;
            end else if (cnt_q == CNT_LAST) begin
                // Abandon: retire as a non-writing instruction so upstream can move on.
                state_d   = S_IDLE;
                req_d     = 1'b0;
                valid_d   = 1'b1;
                rd_d      = ctx_q.rd;
                result_d  = ctx_q.alt;
                bus_err_d = 1'b1;
            end else begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            cnt_q      <= '0;
            ctx_q      <= '0;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            ctx_q      <= ctx_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            bus_err_q  <= bus_err_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) misalign_q <= 1'b0;
        else         misalign_q <= trap_c & (state_q == S_IDLE);
    end

    assign misalign_o = misalign_q;
`endif

    // Stall is held low during reset so upstream never sees a stale hold.
    assign stall_o         = stall_c & rst_ni;
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_be_o    = be_q;
    assign valid_o         = valid_q;
    assign RegWrite_o      = regwrite_q;
    assign rd_o            = rd_q;
    assign result_o        = result_q;
    assign bus_err_o       = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a configurable-latency memory responder.
// Build with MISALIGN_TRAP_EN defined to exercise the misalignment trap.
module tb_mem_access_stage;
    localparam int unsigned TMO = 4;
    localparam logic [31:0] PC4_V = 32'h0000_1004;
    localparam logic [31:0] IMM_V = 32'hABCD_E000;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        logic        chk;
        logic        berr;
        logic        mis;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] ALUout_i = '0;
    logic [31:0] regOp2_i = '0;
    logic        RegWrite_i = 1'b0;
    logic [1:0]  WriteSrc_i = '0;
    logic        MemWrite_i = 1'b0;
    logic [2:0]  memSize_i = '0;
    logic [31:0] ImmOp_i = IMM_V;
    logic [31:0] pcPlus4_i = PC4_V;
    logic [4:0]  rd_i = '0;
    logic        stall_o, valid_o, RegWrite_o, bus_err_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_access_stage_if #(.ADDR_W(32)) mif ();

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ALUout_i(ALUout_i),
        .regOp2_i(regOp2_i), .RegWrite_i(RegWrite_i), .WriteSrc_i(WriteSrc_i),
        .MemWrite_i(MemWrite_i), .memSize_i(memSize_i), .ImmOp_i(ImmOp_i),
        .pcPlus4_i(pcPlus4_i), .rd_i(rd_i), .stall_o(stall_o), .mem(mif),
        .valid_o(valid_o), .RegWrite_o(RegWrite_o), .rd_o(rd_o),
        .result_o(result_o), .bus_err_o(bus_err_o)
`ifdef MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    wb_t  exp_wb[$];
    req_t exp_req[$];
    logic [31:0] rdata_cfg = '0;
    int   ack_wait = 1;
    logic no_ack = 1'b0;
    int   wait_cnt = 0;
    logic has_req = 1'b0;
    req_t cur_req;

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] sz);
        logic [31:0] b, h;
        b = w >> (8 * a);
        h = w >> (16 * a[1]);
        case (sz)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return b & 32'h0000_00FF;
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return h & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'b000, 3'b100: return 4'(1 << a);
            3'b001, 3'b101: return a[1] ? 4'hC : 4'h3;
            default:        return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] d);
        case (sz)
            3'b000, 3'b100: return {24'd0, d[7:0]} * 32'h0101_0101;
            3'b001, 3'b101: return {16'd0, d[15:0]} * 32'h0001_0001;
            default:        return d;
        endcase
    endfunction

    function automatic logic misaligned_model(input logic [2:0] sz, input logic [1:0] a);
        if (sz == 3'b000 || sz == 3'b100) return 1'b0;
        if (sz == 3'b001 || sz == 3'b101) return a[0];
        return a != 2'b00;
    endfunction

    // Memory responder: acks in the ack_wait-th WAIT cycle and checks request stability.
    always @(posedge clk) begin
        #1;
        if (rst_ni && mif.mem_req_o && !mif.mem_ack_i) begin
            wait_cnt++;
            if (wait_cnt == 1) begin
                n_checks++;
                if (exp_req.size() == 0) begin
                    $display("FAIL unexpected_req: got req addr=%h, required no request", mif.mem_addr_o);
                    has_req = 1'b0;
                end else begin
                    n_pass++;
                    cur_req = exp_req.pop_front();
                    has_req = 1'b1;
                end
            end
            if (has_req) begin
                n_checks++;
                if (mif.mem_we_o !== cur_req.we || mif.mem_addr_o !== cur_req.addr ||
                    (cur_req.we && (mif.mem_wdata_o !== cur_req.wdata || mif.mem_be_o !== cur_req.be)))
                    $display("FAIL req_fields: got we=%b addr=%h wdata=%h be=%b, required we=%b addr=%h wdata=%h be=%b",
                             mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, mif.mem_be_o,
                             cur_req.we, cur_req.addr, cur_req.wdata, cur_req.be);
                else n_pass++;
            end
            if (!no_ack && wait_cnt >= ack_wait) begin
                mif.mem_ack_i   = 1'b1;
                mif.mem_rdata_i = rdata_cfg;
            end
        end else begin
            mif.mem_ack_i = 1'b0;
            wait_cnt      = 0;
            has_req       = 1'b0;
        end
    end

    // Writeback monitor: every retired instruction is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_ni) begin
            n_checks++;
            if (valid_o) begin
                if (exp_wb.size() == 0) begin
                    $display("FAIL unexpected_wb: got rd=%0d result=%h, required no retirement", rd_o, result_o);
                end else begin
                    wb_t e;
                    logic ok;
                    e  = exp_wb.pop_front();
                    ok = (rd_o === e.rd) && (RegWrite_o === e.rw) && (bus_err_o === e.berr) &&
                         (!e.chk || result_o === e.res);
`ifdef MISALIGN_TRAP_EN
                    ok = ok && (misalign_o === e.mis);
`endif
                    if (!ok)
                        $display("FAIL wb: got rd=%0d rw=%b err=%b res=%h, required rd=%0d rw=%b err=%b res=%h",
                                 rd_o, RegWrite_o, bus_err_o, result_o, e.rd, e.rw, e.berr, e.res);
                    else n_pass++;
                end
            end else if (RegWrite_o !== 1'b0 || bus_err_o !== 1'b0) begin
                $display("FAIL bubble: got rw=%b err=%b, required 0 0", RegWrite_o, bus_err_o);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] op2, input logic rw,
                         input logic [1:0] ws, input logic mw, input logic [2:0] sz, input logic [4:0] rd,
                         output int stalls);
        wb_t  e;
        req_t r;
        logic mem_op, mis;
        mem_op = v && (mw || ws == 2'b01);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = mem_op && misaligned_model(sz, alu[1:0]);
`endif
        valid_i = v; ALUout_i = alu; regOp2_i = op2; RegWrite_i = rw;
        WriteSrc_i = ws; MemWrite_i = mw; memSize_i = sz; rd_i = rd;
        e.rd = rd; e.mis = mis; e.berr = 1'b0; e.chk = 1'b1; e.rw = rw; e.res = '0;
        if (mis) begin
            e.rw = 1'b0; e.chk = 1'b0;
        end else if (mem_op && no_ack) begin
            e.rw = 1'b0; e.berr = 1'b1; e.chk = 1'b0;
        end else if (mem_op && mw) begin
            e.chk = 1'b0;
        end else if (mem_op) begin
            e.res = exp_load(rdata_cfg, alu[1:0], sz);
        end else begin
            e.res = (ws == 2'b10) ? PC4_V : (ws == 2'b11) ? IMM_V : alu;
        end
        if (v) exp_wb.push_back(e);
        if (mem_op && !mis) begin
            r.we = mw; r.addr = alu & 32'hFFFF_FFFC;
            r.wdata = exp_wdata(sz, op2); r.be = exp_be(sz, alu[1:0]);
            exp_req.push_back(r);
        end
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
        end
        if (stalls >= 64) begin
            n_checks++;
            $display("FAIL stall_bound: got stall held 64 cycles, required release");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0; MemWrite_i = 1'b0; WriteSrc_i = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mif.mem_req_o, valid_o, RegWrite_o, bus_err_o, stall_o} !== 5'b0)
            $display("FAIL reset_state: got req/valid/rw/err/stall=%b, required 00000",
                     {mif.mem_req_o, valid_o, RegWrite_o, bus_err_o, stall_o});
        else n_pass++;
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        int s;
        issue(1, 32'h1234, 0, 1, 2'b00, 0, 3'b010, 5'd5, s);
        n_checks++;
        if (s !== 0 || valid_o !== 1'b1 || result_o !== 32'h1234 || rd_o !== 5'd5)
            $display("FAIL alu: got stalls=%0d valid=%b res=%h rd=%0d, required 0 1 00001234 5", s, valid_o, result_o, rd_o);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_load_byte();
        int s;
        rdata_cfg = 32'h80FF_FFFF; ack_wait = 2;
        issue(1, 32'h103, 0, 1, 2'b01, 0, 3'b000, 5'd7, s);
        n_checks++;
        if (s !== 2 || valid_o !== 1'b1 || result_o !== 32'hFFFF_FF80)
            $display("FAIL lb: got stalls=%0d valid=%b res=%h, required 2 1 ffffff80", s, valid_o, result_o);
        else n_pass++;
        issue(1, 32'h103, 0, 1, 2'b01, 0, 3'b100, 5'd8, s);
        n_checks++;
        if (s !== 2 || result_o !== 32'h0000_0080)
            $display("FAIL lbu: got stalls=%0d res=%h, required 2 00000080", s, result_o);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_store_half();
        int s;
        ack_wait = 3;
        issue(1, 32'h102, 32'hABCD_1234, 0, 2'b00, 1, 3'b001, 5'd0, s);
        n_checks++;
        if (s !== 3 || valid_o !== 1'b1 || RegWrite_o !== 1'b0)
            $display("FAIL sh: got stalls=%0d valid=%b rw=%b, required 3 1 0", s, valid_o, RegWrite_o);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_timeout();
        int s;
        no_ack = 1'b1;
        issue(1, 32'h300, 0, 1, 2'b01, 0, 3'b010, 5'd9, s);
        n_checks++;
        if (s !== int'(TMO) || bus_err_o !== 1'b1 || RegWrite_o !== 1'b0 || mif.mem_req_o !== 1'b0)
            $display("FAIL timeout: got stalls=%0d err=%b rw=%b req=%b, required %0d 1 0 0",
                     s, bus_err_o, RegWrite_o, mif.mem_req_o, TMO);
        else n_pass++;
        no_ack = 1'b0;
        issue(1, 32'h0, 0, 1, 2'b10, 0, 3'b010, 5'd10, s);
        n_checks++;
        if (s !== 0 || result_o !== PC4_V || bus_err_o !== 1'b0)
            $display("FAIL after_timeout: got stalls=%0d res=%h err=%b, required 0 %h 0", s, result_o, bus_err_o, PC4_V);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int s;
        ack_wait = 1;
        issue(1, 32'h101, 32'h0000_005A, 0, 2'b00, 1, 3'b000, 5'd0, s);
        rdata_cfg = 32'hBEEF_1234;
        issue(1, 32'h102, 0, 1, 2'b01, 0, 3'b101, 5'd11, s);
        rdata_cfg = 32'h0000_8001;
        issue(1, 32'h0, 0, 1, 2'b01, 0, 3'b001, 5'd12, s);
        issue(1, 32'h0, 0, 1, 2'b11, 0, 3'b010, 5'd13, s);
        n_checks++;
        if (s !== 0 || result_o !== IMM_V)
            $display("FAIL lui: got stalls=%0d res=%h, required 0 %h", s, result_o, IMM_V);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_misaligned();
        int s;
        rdata_cfg = 32'h1122_3344; ack_wait = 1;
        issue(1, 32'h101, 0, 1, 2'b01, 0, 3'b010, 5'd14, s);
`ifdef MISALIGN_TRAP_EN
        n_checks++;
        if (s !== 0 || misalign_o !== 1'b1 || RegWrite_o !== 1'b0 || valid_o !== 1'b1)
            $display("FAIL misalign: got stalls=%0d mis=%b rw=%b valid=%b, required 0 1 0 1", s, misalign_o, RegWrite_o, valid_o);
        else n_pass++;
        idle(1);
        n_checks++;
        if (misalign_o !== 1'b0)
            $display("FAIL misalign_pulse: got %b, required 0", misalign_o);
        else n_pass++;
`else
        n_checks++;
        if (s !== 1 || result_o !== 32'h1122_3344 || RegWrite_o !== 1'b1)
            $display("FAIL misaligned_lw: got stalls=%0d res=%h rw=%b, required 1 11223344 1", s, result_o, RegWrite_o);
        else n_pass++;
`endif
        idle(2);
    endtask

    task automatic test_reset_mid_wait();
        int s;
        req_t r;
        no_ack = 1'b1;
        r.we = 1'b0; r.addr = 32'h200; r.wdata = '0; r.be = 4'hF;
        exp_req.push_back(r);
        valid_i = 1'b1; ALUout_i = 32'h200; RegWrite_i = 1'b1; WriteSrc_i = 2'b01;
        MemWrite_i = 1'b0; memSize_i = 3'b010; rd_i = 5'd15;
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (mif.mem_req_o !== 1'b0 || valid_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL reset_mid_wait: got req=%b valid=%b stall=%b, required 0 0 0", mif.mem_req_o, valid_o, stall_o);
        else n_pass++;
        valid_i = 1'b0;
        exp_wb.delete();
        exp_req.delete();
        no_ack = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        rdata_cfg = 32'hCAFE_F00D; ack_wait = 1;
        issue(1, 32'h204, 0, 1, 2'b01, 0, 3'b010, 5'd16, s);
        n_checks++;
        if (s !== 1 || valid_o !== 1'b1 || result_o !== 32'hCAFE_F00D)
            $display("FAIL lw_after_reset: got stalls=%0d valid=%b res=%h, required 1 1 cafef00d", s, valid_o, result_o);
        else n_pass++;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = '0;
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_timeout();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_wait();
        idle(3);
        n_checks++;
        if (exp_wb.size() != 0 || exp_req.size() != 0)
            $display("FAIL drain: got wb=%0d req=%0d pending, required 0 0", exp_wb.size(), exp_req.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
